hpdl_multi_ctrl: RTL and testbench



---
 rtl/hpdl_pkg.sv | 29 ++
 rtl/hpdl_scan_timer.sv | 95 +++++++++
 rtl/hpdl_multi_ctrl.sv | 146 ++++++++++++++
 tb/tb_hpdl_multi_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdl_pkg.sv
// Shared constants and scan-state type for the HPDL-1414 chain controller.
package hpdl_pkg;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_BKSP   = 8'h08;
  localparam logic [7:0] CH_DEL    = 8'h7F;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] CH_CURSOR = 8'h5F;

  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h5F;
  localparam logic [7:0] LOWER_LO  = 8'h61;
  localparam logic [7:0] LOWER_HI  = 8'h7A;
  localparam logic [7:0] CASE_OFS  = 8'h20;

  typedef enum logic [1:0] {
    SETUP  = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  // The display has no lower-case glyphs, so a..z are folded onto A..Z.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    if ((b >= LOWER_LO) && (b <= LOWER_HI)) return b - CASE_OFS;
    return b;
  endfunction

endpackage

// File: rtl/hpdl_scan_timer.sv
// Slot sequencer: SETUP -> STROBE -> HOLD per display position, with per-device
// registered strobes and the current scan position.
module hpdl_scan_timer
  import hpdl_pkg::*;
#(
  parameter int NUM_DEVICES = 4,
  parameter int SETUP_CYC   = 64,
  parameter int STROBE_CYC  = 256,
  parameter int HOLD_CYC    = 64,
  parameter int PW          = $clog2(4 * NUM_DEVICES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic                   o_slot_start,
  output logic [NUM_DEVICES-1:0] o_strobe_active,
  output logic [PW-1:0]          o_scan_pos,
  output scan_state_e            o_state
);

  localparam int NPOS    = 4 * NUM_DEVICES;
  localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [PW-1:0] POS_LAST    = PW'(NPOS - 1);

  scan_state_e            r_state;
  scan_state_e            w_state_nxt;
  logic [CW-1:0]          r_phase;
  logic [CW-1:0]          w_phase_nxt;
  logic [PW-1:0]          r_scan_pos;
  logic [PW-1:0]          w_pos_nxt;
  logic [NUM_DEVICES-1:0] r_strobe;
  logic [NUM_DEVICES-1:0] w_strobe_nxt;
  logic                   w_slot_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= SETUP;
      r_phase    <= '0;
      r_scan_pos <= '0;
      r_strobe   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_scan_pos <= w_pos_nxt;
      r_strobe   <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase + 1'b1;
    w_pos_nxt    = r_scan_pos;
    w_slot_start = 1'b0;
    w_strobe_nxt = '0;
    case (r_state)
      SETUP: begin
        if (r_phase == SETUP_LAST) begin
          w_state_nxt = STROBE;
          w_phase_nxt = '0;
        end
      end
      STROBE: begin
        if (r_phase == STROBE_LAST) begin
          w_state_nxt = HOLD;
          w_phase_nxt = '0;
        end
      end
      HOLD: begin
        if (r_phase == HOLD_LAST) begin
          w_state_nxt  = SETUP;
          w_phase_nxt  = '0;
          w_pos_nxt    = (r_scan_pos == POS_LAST) ? '0 : r_scan_pos + 1'b1;
          w_slot_start = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SETUP;
        w_phase_nxt = '0;
      end
    endcase
    // Strobe is registered from the next state so WR_N comes straight off a flop.
    if (w_state_nxt == STROBE) w_strobe_nxt = NUM_DEVICES'(1) << (r_scan_pos >> 2);
  end

  assign o_slot_start    = w_slot_start;
  assign o_strobe_active = r_strobe;
  assign o_scan_pos      = r_scan_pos;
  assign o_state         = r_state;

endmodule

// File: rtl/hpdl_multi_ctrl.sv
// HPDL-1414 chain controller: frame buffer, byte decode and D/A/WR_N drive.
// Optional cursor blink is enabled by defining HPDL_CURSOR_BLINK_EN.
module hpdl_multi_ctrl
  import hpdl_pkg::*;
#(
  parameter int NUM_DEVICES = 4,
  parameter int SETUP_CYC   = 64,
  parameter int STROBE_CYC  = 256,
  parameter int HOLD_CYC    = 64,
  parameter int SCROLL_MODE = 0,
  parameter int PW          = $clog2(4 * NUM_DEVICES)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  input  logic [7:0]             IN_DATA,
  output logic                   IN_READY,
  output logic [6:0]             HPDL_D,
  output logic [1:0]             HPDL_A,
  output logic [NUM_DEVICES-1:0] HPDL_WR_N,
  output logic [PW-1:0]          CURSOR
);

  localparam int NPOS = 4 * NUM_DEVICES;
  localparam logic [PW-1:0] POS_LAST = PW'(NPOS - 1);

  logic                   w_slot_start;
  logic [NUM_DEVICES-1:0] w_strobe_active;
  logic [PW-1:0]          w_scan_pos;
  scan_state_e            w_scan_state;

  hpdl_scan_timer #(
    .NUM_DEVICES (NUM_DEVICES),
    .SETUP_CYC   (SETUP_CYC),
    .STROBE_CYC  (STROBE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .PW          (PW)
  ) u_scan_timer (
    .i_clk           (CLK),
    .i_rst_n         (RST_N),
    .o_slot_start    (w_slot_start),
    .o_strobe_active (w_strobe_active),
    .o_scan_pos      (w_scan_pos),
    .o_state         (w_scan_state)
  );

  // Handshake: a byte transfers on a CLK edge where IN_VALID && IN_READY; the
  // single slot then spends one cycle decoding with IN_READY low.
  logic          r_ready;
  logic          r_pend;
  logic [7:0]    r_byte;
  logic [6:0]    r_buf [NPOS];
  logic [PW-1:0] r_cursor;
  logic [6:0]    r_d;
  logic [1:0]    r_a;

  logic [7:0]    w_ch;
  logic          w_print;
  logic          w_cur_last;
  logic [PW-1:0] w_load_pos;
  logic          w_blank_cursor;
  logic [6:0]    w_load_char;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ready <= 1'b1;
      r_pend  <= 1'b0;
      r_byte  <= '0;
    end else if (IN_VALID && r_ready) begin
      r_byte  <= IN_DATA;
      r_pend  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_pend  <= 1'b0;
      r_ready <= 1'b1;
    end
  end

  assign w_ch       = fold_case(r_byte);
  assign w_print    = (w_ch >= PRINT_LO) && (w_ch <= PRINT_HI);
  assign w_cur_last = (r_cursor == POS_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NPOS; i++) r_buf[i] <= CH_SPACE[6:0];
      r_cursor <= '0;
    end else if (r_pend) begin
      if (w_print) begin
        if ((SCROLL_MODE == 1) && w_cur_last) begin
          // Write at the last cell, then shift the whole frame left by one.
          for (int i = 0; i < NPOS - 1; i++) r_buf[i] <= r_buf[i+1];
          r_buf[NPOS-2] <= w_ch[6:0];
          r_buf[NPOS-1] <= CH_SPACE[6:0];
        end else begin
          r_buf[r_cursor] <= w_ch[6:0];
          r_cursor        <= w_cur_last ? '0 : r_cursor + 1'b1;
        end
      end else if ((r_byte == CH_BKSP) || (r_byte == CH_DEL)) begin
        if (r_cursor != '0) begin
          r_cursor                <= r_cursor - 1'b1;
          r_buf[r_cursor - 1'b1]  <= CH_SPACE[6:0];
        end
      end else if (r_byte == CH_CR) begin
        r_cursor <= '0;
      end else if (r_byte == CH_FF) begin
        for (int i = 0; i < NPOS; i++) r_buf[i] <= CH_SPACE[6:0];
        r_cursor <= '0;
      end
    end
  end

  assign w_load_pos = (w_scan_pos == POS_LAST) ? '0 : w_scan_pos + 1'b1;

`ifdef HPDL_CURSOR_BLINK_EN
  logic [21:0] r_blink;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_blink <= '0;
    else        r_blink <= r_blink + 1'b1;
  end

  assign w_blank_cursor = r_blink[21] && (w_load_pos == r_cursor);
`else
  assign w_blank_cursor = 1'b0;
`endif

  assign w_load_char = w_blank_cursor ? CH_CURSOR[6:0] : r_buf[w_load_pos];

  // D/A only move on the HOLD->SETUP edge, so writes mid-slot never disturb a strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_d <= CH_SPACE[6:0];
      r_a <= 2'b11;
    end else if (w_slot_start && (w_scan_state == HOLD)) begin
      r_d <= w_load_char;
      r_a <= ~w_load_pos[1:0];
    end
  end

  assign IN_READY  = r_ready;
  assign HPDL_D    = r_d;
  assign HPDL_A    = r_a;
  assign HPDL_WR_N = ~w_strobe_active;
  assign CURSOR    = r_cursor;

endmodule

// File: tb/tb_hpdl_multi_ctrl.sv
// Scoreboard bench for hpdl_multi_ctrl: one wrap-mode and one scroll-mode instance share stimulus.
module tb_hpdl_multi_ctrl;

  localparam int ND   = 4;
  localparam int NPOS = 16;
  localparam int SU   = 4;
  localparam int ST   = 8;
  localparam int HO   = 4;
  localparam int W    = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy0, rdy1;
  logic [6:0] d0, d1;
  logic [1:0] a0, a1;
  logic [3:0] wr0, wr1;
  logic [3:0] cur0, cur1;

  always #5 clk = ~clk;

  hpdl_multi_ctrl #(
    .NUM_DEVICES(ND), .SETUP_CYC(SU), .STROBE_CYC(ST), .HOLD_CYC(HO), .SCROLL_MODE(0)
  ) u_dut_wrap (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(rdy0),
    .HPDL_D(d0), .HPDL_A(a0), .HPDL_WR_N(wr0), .CURSOR(cur0)
  );

  hpdl_multi_ctrl #(
    .NUM_DEVICES(ND), .SETUP_CYC(SU), .STROBE_CYC(ST), .HOLD_CYC(HO), .SCROLL_MODE(1)
  ) u_dut_scroll (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(rdy1),
    .HPDL_D(d1), .HPDL_A(a1), .HPDL_WR_N(wr1), .CURSOR(cur1)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [6:0]   frame0 [NPOS];
  logic [6:0]   frame1 [NPOS];

  int         fall_cnt = 0;
  int         last_pos = -1;
  logic [3:0] prev_wr  [2];
  bit         in_pulse [2];
  int         width    [2];
  logic [8:0] held_ad  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every falling strobe is decoded into {onehot, position, data} and
  // compared with the head of that instance's expected queue.
  task automatic mon_step(input int inst, input logic [3:0] wr, input logic [6:0] d,
                          input logic [1:0] a);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    int zeros;
    int dev;
    if (!rst_n) begin
      in_pulse[inst] = 1'b0;
      prev_wr[inst]  = 4'hF;
      return;
    end
    if (prev_wr[inst] == 4'hF && wr != 4'hF) begin
      zeros = 0;
      dev   = 0;
      for (int k = 0; k < ND; k++) if (!wr[k]) begin zeros++; dev = k; end
      obs = {(zeros == 1), 4'(dev * 4 + 3 - int'(a)), d};
      if (inst == 0) begin
        fall_cnt++;
        last_pos = dev * 4 + 3 - int'(a);
      end
      if (inst == 0 && exp_q0.size() > 0) begin
        exp = exp_q0.pop_front();
        check("strobe_wrap {onehot,pos,d}", obs, exp);
      end else if (inst == 1 && exp_q1.size() > 0) begin
        exp = exp_q1.pop_front();
        check("strobe_scroll {onehot,pos,d}", obs, exp);
      end
      in_pulse[inst] = 1'b1;
      width[inst]    = 1;
      held_ad[inst]  = {a, d};
    end else if (in_pulse[inst] && wr != 4'hF) begin
      width[inst]++;
    end else if (in_pulse[inst]) begin
      check("strobe_width", width[inst], ST);
      check("da_stable_through_strobe", {a, d}, held_ad[inst]);
      in_pulse[inst] = 1'b0;
    end
    prev_wr[inst] = wr;
  endtask

  always @(negedge clk) begin
    mon_step(0, wr0, d0, a0);
    mon_step(1, wr1, d1, a1);
  end

  task automatic push_frame(input int start);
    int p;
    for (int i = 0; i < NPOS; i++) begin
      p = (start + i) % NPOS;
      exp_q0.push_back({1'b1, 4'(p), frame0[p]});
      exp_q1.push_back({1'b1, 4'(p), frame1[p]});
    end
  endtask

  task automatic set_frames_blank();
    for (int i = 0; i < NPOS; i++) begin
      frame0[i] = 7'h20;
      frame1[i] = 7'h20;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    @(negedge clk);
    while (!rdy0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    check("ready_low_after_accept_wrap", rdy0, 1'b0);
    check("ready_low_after_accept_scroll", rdy1, 1'b0);
    @(negedge clk);
    check("ready_back_high_wrap", rdy0, 1'b1);
    check("ready_back_high_scroll", rdy1, 1'b1);
  endtask

  task automatic sync_pos(input int p);
    int n0 = fall_cnt;
    int budget = 0;
    while (budget < 2000) begin
      @(posedge clk);
      budget++;
      if (fall_cnt != n0) begin
        if (last_pos == p) return;
        n0 = fall_cnt;
      end
    end
    checks++;
    errors++;
    $display("FAIL sync_pos: no strobe for position %0d within 2000 cycles", p);
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d strobes still expected, required 0",
               exp_q0.size(), exp_q1.size());
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  task automatic release_and_time(input string name);
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (wr0 == 4'hF && n < 40);
    check(name, n, SU);
  endtask

  initial begin
    prev_wr[0] = 4'hF; prev_wr[1] = 4'hF;
    in_pulse[0] = 1'b0; in_pulse[1] = 1'b0;
    width[0] = 0; width[1] = 0;
    held_ad[0] = '0; held_ad[1] = '0;

    // Reset state, then an idle frame of spaces scanned 3,2,1,0 per device.
    repeat (3) @(negedge clk);
    check("reset_in_ready", rdy0, 1'b1);
    check("reset_cursor", cur0, 4'd0);
    check("reset_wr_n_wrap", wr0, 4'hF);
    check("reset_wr_n_scroll", wr1, 4'hF);
    check("reset_addr", a0, 2'b11);
    check("reset_data", d0, 7'h20);
    set_frames_blank();
    push_frame(0);
    release_and_time("first_strobe_after_reset_cycles");
    drain();

    // 'H','i' sent during slot 0: slot 0 keeps its latched space, slot 1 shows 'I'.
    sync_pos(0);
    send_byte(8'h48);
    send_byte(8'h69);
    check("cursor_after_hi_wrap", cur0, 4'd2);
    check("cursor_after_hi_scroll", cur1, 4'd2);
    frame0[0] = 7'h48; frame0[1] = 7'h49;
    frame1[0] = 7'h48; frame1[1] = 7'h49;
    push_frame(1);
    drain();

    // CR, backspace at 0 is a no-op; 'x' then DEL erases cell 0 again.
    send_byte(8'h0D);
    check("cursor_after_cr", cur0, 4'd0);
    send_byte(8'h08);
    check("cursor_bksp_at_zero", cur0, 4'd0);
    send_byte(8'h78);
    check("cursor_after_x", cur0, 4'd1);
    send_byte(8'h7F);
    check("cursor_after_del", cur0, 4'd0);
    frame0[0] = 7'h20;
    frame1[0] = 7'h20;
    sync_pos(15);
    push_frame(0);
    drain();

    // Clear, then 17 letters 'A'..'Q': wrap vs scroll behaviour.
    send_byte(8'h0C);
    for (int i = 0; i < 17; i++) send_byte(8'h41 + 8'(i));
    check("cursor_17_wrap", cur0, 4'd1);
    check("cursor_17_scroll", cur1, 4'd15);
    frame0[0] = 7'h51;
    for (int i = 1; i < NPOS; i++) frame0[i] = 7'h41 + 7'(i);
    for (int i = 0; i < NPOS - 1; i++) frame1[i] = 7'h43 + 7'(i);
    frame1[NPOS-1] = 7'h20;
    sync_pos(15);
    push_frame(0);
    drain();

    // Full frame cleared by FF; CR at 0; non-printables ignored; range edges.
    send_byte(8'h0C);
    check("cursor_after_ff_wrap", cur0, 4'd0);
    check("cursor_after_ff_scroll", cur1, 4'd0);
    send_byte(8'h0D);
    send_byte(8'h01);
    send_byte(8'h60);
    send_byte(8'h7B);
    send_byte(8'h1F);
    check("cursor_after_ignored", cur0, 4'd0);
    send_byte(8'h5F);
    send_byte(8'h7A);
    send_byte(8'h61);
    send_byte(8'h20);
    check("cursor_after_edges", cur0, 4'd4);
    set_frames_blank();
    frame0[0] = 7'h5F; frame0[1] = 7'h5A; frame0[2] = 7'h41;
    frame1[0] = 7'h5F; frame1[1] = 7'h5A; frame1[2] = 7'h41;
    sync_pos(15);
    push_frame(0);
    drain();

    // Reset mid-STROBE of slot 5 (device 1): WR_N releases at once, scan restarts at 0.
    sync_pos(5);
    @(negedge clk);
    check("strobe_active_before_reset", wr0, 4'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    check("wr_n_async_release_wrap", wr0, 4'hF);
    check("wr_n_async_release_scroll", wr1, 4'hF);
    check("cursor_in_reset", cur0, 4'd0);
    check("addr_in_reset", a0, 2'b11);
    repeat (2) @(negedge clk);
    set_frames_blank();
    push_frame(0);
    release_and_time("first_strobe_after_midstrobe_reset_cycles");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
